// File: rtl/edge_pkg.sv
// Shared constants and helpers for the edge detector bank.
package edge_pkg;

  // Per-channel edge mode encoding.
  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  // Width of a counter that must hold 0 .. filter_cycles.
  function automatic int unsigned cnt_width(input int unsigned filter_cycles);
    return $clog2(filter_cycles + 1);
  endfunction

  // True when a filtered transition to new_level should produce a pulse in this mode.
  function automatic logic edge_hit(input logic [1:0] mode, input logic new_level);
    logic hit;
    hit = 1'b0;
    if (new_level) begin
      hit = (mode == MODE_RISE) || (mode == MODE_BOTH);
    end else begin
      hit = (mode == MODE_FALL) || (mode == MODE_BOTH);
    end
    return hit;
  endfunction

endpackage

// File: rtl/edge_detect_bank_if.sv
// Pin-side and event-side signals of the edge detector bank.
interface edge_detect_bank_if #(
  parameter int unsigned CHANNELS = 4
);

  logic [CHANNELS-1:0]   sig_in;
  logic [2*CHANNELS-1:0] mode;
  logic [CHANNELS-1:0]   evt_clr;
  logic [CHANNELS-1:0]   level_out;
  logic [CHANNELS-1:0]   pulse_out;
  logic [CHANNELS-1:0]   evt_flag;
  logic                  any_evt;

  // Controller side: drives pins, mode and clears; observes events.
  modport master (
    output sig_in,
    output mode,
    output evt_clr,
    input  level_out,
    input  pulse_out,
    input  evt_flag,
    input  any_evt
  );

  // Detector side.
  modport slave (
    input  sig_in,
    input  mode,
    input  evt_clr,
    output level_out,
    output pulse_out,
    output evt_flag,
    output any_evt
  );

endinterface

// File: rtl/edge_chan.sv
// One detector channel: synchroniser, glitch filter, edge pulse and sticky flag.
module edge_chan
  import edge_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 1,
  parameter logic        INIT_LEVEL    = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sig_in,
  input  logic [1:0] mode,
  input  logic       evt_clr,
  output logic       level_out,
  output logic       pulse_out,
  output logic       evt_flag
);

  localparam int unsigned    CNT_W   = cnt_width(FILTER_CYCLES);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(FILTER_CYCLES - 1);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (FILTER_CYCLES < 1) begin : g_bad_filter
    $error("FILTER_CYCLES must be at least 1");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   filt_q, filt_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   pulse_q, pulse_d;
  logic                   flag_q, flag_d;

  // Synchroniser shift chain; the oldest stage feeds the filter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= {SYNC_STAGES{INIT_LEVEL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  // Filter accepts a new level only after it has persisted for FILTER_CYCLES samples.
  always_comb begin
    filt_d  = filt_q;
    cnt_d   = '0;
    pulse_d = 1'b0;
    if (synced != filt_q) begin
      if (cnt_q == CntLast) begin
        filt_d  = synced;
        pulse_d = edge_hit(mode, synced);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    // A new pulse wins over a same-cycle clear.
    flag_d = (flag_q & ~evt_clr) | pulse_d;
  end

  // Filter, pulse and flag state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_q  <= INIT_LEVEL;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      flag_q  <= flag_d;
    end
  end

  assign level_out = filt_q;
  assign pulse_out = pulse_q;
  assign evt_flag  = flag_q;

endmodule

// File: rtl/edge_detect_bank.sv
// Bank of independent edge detector channels with a combined event indication.
module edge_detect_bank
  import edge_pkg::*;
#(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 1,
  parameter logic        INIT_LEVEL    = 1'b0
) (
  input logic               clk,
  input logic               rst,
  edge_detect_bank_if.slave bus
);

  if (CHANNELS < 1) begin : g_bad_channels
    $error("CHANNELS must be at least 1");
  end

  logic [CHANNELS-1:0] level_w;
  logic [CHANNELS-1:0] pulse_w;
  logic [CHANNELS-1:0] flag_w;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    edge_chan #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES),
      .INIT_LEVEL   (INIT_LEVEL)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .sig_in   (bus.sig_in[i]),
      .mode     (bus.mode[2*i +: 2]),
      .evt_clr  (bus.evt_clr[i]),
      .level_out(level_w[i]),
      .pulse_out(pulse_w[i]),
      .evt_flag (flag_w[i])
    );
  end

  assign bus.level_out = level_w;
  assign bus.pulse_out = pulse_w;
  assign bus.evt_flag  = flag_w;
  // Flags are registered, so this summary is glitch-free.
  assign bus.any_evt   = |flag_w;

endmodule

// File: doc/edge_detect_bank.md
# edge_detect_bank

Parametrised multi-channel successor to the single-input rising-edge detector used in the UART front end. Each channel synchronises an asynchronous input, debounces it with a programmable glitch filter, and detects rising, falling or both edges per a per-channel mode. It emits one-cycle pulses plus sticky, write-1-to-clear event flags. Sits between raw pins or cross-domain strobes (RX line, buttons, handshake lines) and the UART control logic.

## Interface
- CHANNELS, 4: number of independent channels (≥1)
- SYNC_STAGES, 2: synchroniser flops per channel (≥2)
- FILTER_CYCLES, 1: consecutive synced cycles a new level must persist before it is accepted (≥1; 1 = no filtering)
- INIT_LEVEL, 1'b0: reset value of every synchroniser flop and filtered level
- CNT_W, $clog2(FILTER_CYCLES+1): filter counter width (derived, not overridden)
---
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset (asserted at 0)
- sig_in  in  CHANNELS  asynchronous inputs
- mode  in  2*CHANNELS  per-channel mode, channel i at [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
- evt_clr  in  CHANNELS  write-1-to-clear for evt_flag, synchronous to clk
- level_out  out  CHANNELS  filtered level
- pulse_out  out  CHANNELS  one-cycle edge pulse
- evt_flag  out  CHANNELS  sticky event flags
- any_evt  out  1  OR of all evt_flag bits

## Operation
- Sync chain: s[0] <= sig_in, s[k] <= s[k-1]; synced = s[SYNC_STAGES-1].
- Filter (per channel): a register filt and a counter cnt.
  - If synced == filt: cnt <= 0.
  - If synced != filt and cnt == FILTER_CYCLES-1: filt <= synced and cnt <= 0. This is a filt update.
  - Otherwise: cnt <= cnt+1.
  - A mismatch shorter than FILTER_CYCLES synced cycles is discarded, with no level change and no pulse.
- level_out = filt, driven directly from the register.
- pulse_out is registered. At the edge where filt updates, pulse_out <= 1 if:
  - rise mode or both mode, and the update is 0→1, or
  - fall mode or both mode, and the update is 1→0.
  - Otherwise pulse_out <= 0. pulse_out is never high on two consecutive cycles.
- mode is sampled at the update edge. Mode 00 suppresses the pulse and the flag, but filt keeps tracking the input.
- evt_flag[i] <= (evt_flag[i] & ~evt_clr[i]) | pulse_set[i], where pulse_set is the same-edge pulse_out next value. If set and clear occur on the same edge, set wins.
- any_evt = |evt_flag, combinational from registers.
- Reset (rst=0): all sync flops and filt go to INIT_LEVEL. cnt, pulse_out and evt_flag go to 0. any_evt is 0.
  - Reset mid-filter abandons the pending transition.
  - After release, an input held at ~INIT_LEVEL produces a normal edge after the full latency.

## Timing
- Edge 0 is the first clk edge at which s[0] captures the new value. A filt update, and the matching pulse_out/level_out change, occurs at edge SYNC_STAGES+FILTER_CYCLES-1.
  - Example: S=2, F=1 gives edge 2, so the outputs are visible in the cycle after edge 2.
- pulse_out width is exactly 1 cycle.
- evt_flag rises on the same edge as pulse_out.
- evt_clr takes effect on the next edge.
- Minimum accepted input pulse is FILTER_CYCLES clk cycles once synchronised.
- Back-to-back opposite transitions are each detected if every level persists for FILTER_CYCLES cycles.
- Channels are fully independent. Simultaneous events on several channels are all captured.

## Structure
- Package edge_pkg holds:
  - mode constants MODE_OFF=2'b00, MODE_RISE=2'b01, MODE_FALL=2'b10, MODE_BOTH=2'b11
  - a helper function for CNT_W
- Sub-module edge_chan implements one channel: sync chain, filter, pulse register and flag. edge_detect_bank instantiates CHANNELS copies in a generate loop and builds any_evt.

## Test plan
- Reset hold: rst=0 with sig_in toggling → every output is 0; level_out=INIT_LEVEL.
- Basic edges, S=2, F=1, ch0 in mode 11: sig_in[0] 0→1, held for 10 cycles, then 1→0.
  - Two single-cycle pulse_out[0] pulses, each 3 edges after the respective change.
  - level_out[0] tracks the input.
  - evt_flag[0]=1 and any_evt=1.
- Glitch filter, F=4: a 3-cycle high pulse → no pulse and level_out stays 0. A 4-cycle high pulse → level_out rises and exactly one pulse occurs, at edge S+3.
- Mode gating: ch1 in mode 01 and ch2 in mode 10, both driven with the same 0→1→0 waveform.
  - ch1 pulses only on the rise; ch2 pulses only on the fall.
  - A channel in mode 00 never pulses, but its level_out still follows the input.
- Flag clear race: assert evt_clr[0] on the same edge as a new ch0 pulse → evt_flag[0] remains 1. evt_clr[0] alone on the next cycle → evt_flag[0]=0 and any_evt=0.
- Reset mid-operation, F=4: assert rst after 2 mismatched cycles, then release with the input low → no pulse, cnt cleared, and all flags remain 0.
